ctrl_pipe_unit: RTL and testbench

Parametrised instruction control unit for the five-stage pipelined processor. Decodes the 5-bit opcode into a control word and carries the memory and write-back controls down a pipeline of configurable depth, with stall and flush support. Sequences the multi-cycle CALL, RET and RETI operations that the single-cycle control logic does not implement. Sits between fetch/decode and the ALU, memory and write-back stages, alongside the hazard unit.

---
 rtl/ctrl_pipe_unit_pkg.sv | 73 +++++++
 rtl/ctrl_pipe_unit_if.sv | 48 ++++
 rtl/ctrl_pipe_unit_decoder.sv | 50 +++++
 rtl/ctrl_pipe_unit.sv | 174 +++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared definitions for the instruction control unit: opcodes, ALU codes,
// sequencer states and the decoded control word.
package ctrl_pkg;

    localparam int OP_SETC = 1;
    localparam int OP_CLRC = 2;
    localparam int OP_NOT  = 3;
    localparam int OP_INC  = 4;
    localparam int OP_DEC  = 5;
    localparam int OP_IN   = 6;
    localparam int OP_OUT  = 7;
    localparam int OP_PUSH = 8;
    localparam int OP_POP  = 9;
    localparam int OP_LDD  = 10;
    localparam int OP_STD  = 12;
    localparam int OP_LDM  = 13;
    localparam int OP_JZ   = 16;
    localparam int OP_JN   = 17;
    localparam int OP_JC   = 18;
    localparam int OP_CALL = 20;
    localparam int OP_RET  = 21;
    localparam int OP_RETI = 22;
    localparam int OP_MOV  = 24;
    localparam int OP_ADD  = 25;
    localparam int OP_SUB  = 26;
    localparam int OP_AND  = 28;
    localparam int OP_OR   = 29;
    localparam int OP_SHL  = 30;
    localparam int OP_SHR  = 31;

    localparam int ALU_W = 4;
    typedef logic [ALU_W-1:0] alu_op_t;

    localparam alu_op_t ALU_NOT  = 4'd1;
    localparam alu_op_t ALU_INC  = 4'd2;
    localparam alu_op_t ALU_DEC  = 4'd3;
    localparam alu_op_t ALU_MOV  = 4'd4;
    localparam alu_op_t ALU_ADD  = 4'd5;
    localparam alu_op_t ALU_SUB  = 4'd6;
    localparam alu_op_t ALU_AND  = 4'd7;
    localparam alu_op_t ALU_OR   = 4'd8;
    localparam alu_op_t ALU_SHL  = 4'd9;
    localparam alu_op_t ALU_SHR  = 4'd10;
    localparam alu_op_t ALU_SETC = 4'd11;
    localparam alu_op_t ALU_CLRC = 4'd12;
    localparam alu_op_t ALU_ADDR = 4'd13;

    typedef enum logic [1:0] {JMP_NONE, JMP_Z, JMP_N, JMP_C} jump_t;
    typedef enum logic [1:0] {IDLE, CALL_PUSH, RET_FLAGS, RET_POP} state_t;
    typedef enum logic [1:0] {SEQ_NONE, SEQ_CALL, SEQ_RET, SEQ_RETI} seq_t;

    typedef struct packed {
        logic    mem_read;
        logic    mem_write;
        logic    wb;
        alu_op_t alu_op;
        logic    push;
        logic    pop;
        logic    in_port;
        logic    out_port;
        logic    imm;
        logic    one_operand;
        jump_t   jump_type;
        logic    pc_save;
        logic    pc_restore;
        logic    flags_restore;
    } ctrl_word_t;

    function automatic int wsel_width(int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// Bundle of fetch-side inputs and pipelined control outputs of ctrl_pipe_unit.
interface ctrl_pipe_unit_if
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 4,
    parameter int STAGES   = 4,
    parameter int PC_WORDS = 2
);
    localparam int WSEL_W = wsel_width(PC_WORDS);

    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                stall;
    logic                flush;

    logic [STAGES-1:0]   mem_read_pipe;
    logic [STAGES-1:0]   mem_write_pipe;
    logic [STAGES-1:0]   wb_pipe;
    logic [ALU_OP_W-1:0] alu_op_ex;
    logic                push;
    logic                pop;
    logic                in_port;
    logic                out_port;
    logic                imm;
    logic                one_operand;
    logic [1:0]          jump_type;
    logic                pc_save;
    logic                pc_restore;
    logic                flags_restore;
    logic [WSEL_W-1:0]   word_sel;
    logic                busy;

    modport master (
        output opcode, instr_valid, stall, flush,
        input  mem_read_pipe, mem_write_pipe, wb_pipe, alu_op_ex,
        input  push, pop, in_port, out_port, imm, one_operand, jump_type,
        input  pc_save, pc_restore, flags_restore, word_sel, busy
    );

    modport slave (
        input  opcode, instr_valid, stall, flush,
        output mem_read_pipe, mem_write_pipe, wb_pipe, alu_op_ex,
        output push, pop, in_port, out_port, imm, one_operand, jump_type,
        output pc_save, pc_restore, flags_restore, word_sel, busy
    );

endinterface

// File: rtl/ctrl_pipe_unit_decoder.sv
// Combinational opcode decoder: control word plus a request for the
// multi-cycle CALL/RET/RETI sequencer.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    output ctrl_word_t          word,
    output seq_t                seq
);

    always_comb begin
        word = '0;
        seq  = SEQ_NONE;
        if (instr_valid) begin
            case (int'(opcode))
                OP_SETC: word.alu_op = ALU_SETC;
                OP_CLRC: word.alu_op = ALU_CLRC;
                OP_NOT:  begin word.alu_op = ALU_NOT; word.one_operand = 1'b1; end
                OP_INC:  begin word.alu_op = ALU_INC; word.one_operand = 1'b1; end
                OP_DEC:  begin word.alu_op = ALU_DEC; word.one_operand = 1'b1; end
                OP_IN:   word.in_port  = 1'b1;
                OP_OUT:  word.out_port = 1'b1;
                OP_PUSH: word.push     = 1'b1;
                OP_POP:  word.pop      = 1'b1;
                OP_LDD:  begin word.mem_read  = 1'b1; word.alu_op = ALU_ADDR; end
                OP_STD:  begin word.mem_write = 1'b1; word.alu_op = ALU_ADDR; end
                OP_LDM:  begin word.mem_read  = 1'b1; word.imm = 1'b1; end
                OP_MOV:  word.alu_op = ALU_MOV;
                OP_ADD:  word.alu_op = ALU_ADD;
                OP_SUB:  word.alu_op = ALU_SUB;
                OP_AND:  word.alu_op = ALU_AND;
                OP_OR:   word.alu_op = ALU_OR;
                OP_SHL:  begin word.alu_op = ALU_SHL; word.imm = 1'b1; end
                OP_SHR:  begin word.alu_op = ALU_SHR; word.imm = 1'b1; end
                OP_JZ:   word.jump_type = JMP_Z;
                OP_JN:   word.jump_type = JMP_N;
                OP_JC:   word.jump_type = JMP_C;
                OP_CALL: seq = SEQ_CALL;
                OP_RET:  seq = SEQ_RET;
                OP_RETI: seq = SEQ_RETI;
                default: ;
            endcase
        end
        word.wb = ((word.alu_op != '0) || word.mem_read) && !word.mem_write;
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Instruction control unit: registers the decoded word into stage 0, shifts
// memory/write-back controls down the pipe and sequences CALL/RET/RETI.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int ALU_OP_W    = 4,
    parameter int STAGES      = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int PC_WORDS    = 2
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_pipe_unit_if.slave  bus
);

    localparam int                WSEL_W    = wsel_width(PC_WORDS);
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(PC_WORDS - 1);

    ctrl_word_t        dec_word;
    seq_t              dec_seq;
    state_t            state_reg, state_next;
    logic [WSEL_W-1:0] cnt_reg, cnt_next;
    ctrl_word_t        s0_reg, s0_next;
    logic [WSEL_W-1:0] wsel_reg;
    alu_op_t           alu1_reg;
    logic [STAGES-1:0] mr_all, mw_all, wb_all;

    ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
        .opcode      (bus.opcode),
        .instr_valid (bus.instr_valid),
        .word        (dec_word),
        .seq         (dec_seq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // New opcodes are only looked at in IDLE; while busy fetch holds the PC.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (bus.flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (!bus.stall) begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    case (dec_seq)
                        SEQ_CALL: state_next = CALL_PUSH;
                        SEQ_RET:  state_next = RET_POP;
                        SEQ_RETI: state_next = RET_FLAGS;
                        default:  state_next = IDLE;
                    endcase
                end
                RET_FLAGS: begin
                    state_next = RET_POP;
                    cnt_next   = '0;
                end
                default: begin
                    if (cnt_reg == LAST_WORD) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // Step outputs are derived from the next state so they land in stage 0
    // on the same edge that enters the state.
    always_comb begin
        s0_next = '0;
        case (state_next)
            IDLE: begin
                if (state_reg == IDLE) s0_next = dec_word;
            end
            CALL_PUSH: begin
                s0_next.push    = 1'b1;
                s0_next.pc_save = 1'b1;
            end
            RET_FLAGS: begin
                s0_next.pop           = 1'b1;
                s0_next.flags_restore = 1'b1;
            end
            RET_POP: begin
                s0_next.pop        = 1'b1;
                s0_next.pc_restore = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_reg   <= '0;
            wsel_reg <= '0;
        end else if (bus.flush) begin
            s0_reg   <= '0;
            wsel_reg <= '0;
        end else if (!bus.stall) begin
            s0_reg   <= s0_next;
            wsel_reg <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            alu1_reg <= '0;
        else if ((bus.flush && (FLUSH_DEPTH > 1)) || bus.stall)
            alu1_reg <= '0;
        else
            alu1_reg <= s0_reg.alu_op;
    end

    assign mr_all[0] = s0_reg.mem_read;
    assign mw_all[0] = s0_reg.mem_write;
    assign wb_all[0] = s0_reg.wb;

    // Stage 1 takes a bubble on stall while older stages keep draining.
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        localparam bit FLUSHED = (gi < FLUSH_DEPTH);
        localparam bit BUBBLE  = (gi == 1);
        logic mr_q, mw_q, wb_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mr_q <= 1'b0;
                mw_q <= 1'b0;
                wb_q <= 1'b0;
            end else if ((bus.flush && FLUSHED) || (bus.stall && BUBBLE)) begin
                mr_q <= 1'b0;
                mw_q <= 1'b0;
                wb_q <= 1'b0;
            end else begin
                mr_q <= mr_all[gi-1];
                mw_q <= mw_all[gi-1];
                wb_q <= wb_all[gi-1];
            end
        end

        assign mr_all[gi] = mr_q;
        assign mw_all[gi] = mw_q;
        assign wb_all[gi] = wb_q;
    end

    assign bus.mem_read_pipe  = mr_all;
    assign bus.mem_write_pipe = mw_all;
    assign bus.wb_pipe        = wb_all;
    assign bus.alu_op_ex      = ALU_OP_W'(alu1_reg);
    assign bus.push           = s0_reg.push;
    assign bus.pop            = s0_reg.pop;
    assign bus.in_port        = s0_reg.in_port;
    assign bus.out_port       = s0_reg.out_port;
    assign bus.imm            = s0_reg.imm;
    assign bus.one_operand    = s0_reg.one_operand;
    assign bus.jump_type      = s0_reg.jump_type;
    assign bus.pc_save        = s0_reg.pc_save;
    assign bus.pc_restore     = s0_reg.pc_restore;
    assign bus.flags_restore  = s0_reg.flags_restore;
    assign bus.word_sel       = wsel_reg;
    assign bus.busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: directed vectors push hand-computed
// output snapshots, a monitor compares one snapshot after every clock edge.
module tb_ctrl_pipe_unit;

    localparam int OPCODE_W    = 5;
    localparam int ALU_OP_W    = 4;
    localparam int STAGES      = 4;
    localparam int FLUSH_DEPTH = 2;
    localparam int PC_WORDS    = 2;

    // Stage-0 flag bits: {push,pop,in,out,imm,one_op,jt[1:0],pc_save,pc_restore,flags_restore,word_sel}
    localparam logic [11:0] F_NONE = 12'h000;
    localparam logic [11:0] F_PUSH = 12'h800;
    localparam logic [11:0] F_POP  = 12'h400;
    localparam logic [11:0] F_IN   = 12'h200;
    localparam logic [11:0] F_OUT  = 12'h100;
    localparam logic [11:0] F_IMM  = 12'h080;
    localparam logic [11:0] F_ONE  = 12'h040;
    localparam logic [11:0] F_JT1  = 12'h010;
    localparam logic [11:0] F_JT3  = 12'h030;
    localparam logic [11:0] F_PCS  = 12'h008;
    localparam logic [11:0] F_PCR  = 12'h004;
    localparam logic [11:0] F_FR   = 12'h002;
    localparam logic [11:0] F_WS1  = 12'h001;

    typedef struct {
        int          id;
        int          op;
        logic [28:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    exp_t exp_q[$];

    ctrl_pipe_unit_if #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W),
        .STAGES   (STAGES),
        .PC_WORDS (PC_WORDS)
    ) bus ();

    ctrl_pipe_unit #(
        .OPCODE_W    (OPCODE_W),
        .ALU_OP_W    (ALU_OP_W),
        .STAGES      (STAGES),
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .PC_WORDS    (PC_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] snap();
        return {bus.mem_read_pipe, bus.mem_write_pipe, bus.wb_pipe, bus.alu_op_ex,
                bus.push, bus.pop, bus.in_port, bus.out_port, bus.imm, bus.one_operand,
                bus.jump_type, bus.pc_save, bus.pc_restore, bus.flags_restore,
                bus.word_sel, bus.busy};
    endfunction

    task automatic compare(input string name, input logic [28:0] act, input logic [28:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got mr=%b mw=%b wb=%b alu=%0d flags=%h busy=%b required mr=%b mw=%b wb=%b alu=%0d flags=%h busy=%b",
                     name, act[28:25], act[24:21], act[20:17], act[16:13], act[12:1], act[0],
                     exp[28:25], exp[24:21], exp[20:17], exp[16:13], exp[12:1], exp[0]);
        end else begin
            $display("%s ok mr=%b mw=%b wb=%b alu=%0d flags=%h busy=%b",
                     name, act[28:25], act[24:21], act[20:17], act[16:13], act[12:1], act[0]);
        end
    endtask

    // One vector: drive inputs for the coming edge, queue the state expected after it.
    task automatic step(input int op, input bit v, input bit st, input bit fl,
                        input logic [3:0] mr, input logic [3:0] mw, input logic [3:0] wb,
                        input logic [3:0] alu, input logic [11:0] f, input bit bz);
        exp_t e;
        @(negedge clk);
        bus.opcode      = OPCODE_W'(op);
        bus.instr_valid = v;
        bus.stall       = st;
        bus.flush       = fl;
        vec_id++;
        e.id  = vec_id;
        e.op  = op;
        e.exp = {mr, mw, wb, alu, f, bz};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare($sformatf("vec%0d op%0d", e.id, e.op), snap(), e.exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bus.opcode      = '0;
        bus.instr_valid = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        rst             = 1'b1;
        #1;
        compare("reset_state", snap(), 29'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //     op  v  st fl  mr       mw       wb       alu    flags          busy
        // ADD then NOPs: wb walks the pipe, ALU op shows one cycle later
        step(25, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0010, 4'd5,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // STD, then undefined opcode 11
        step(12, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'd0,  F_NONE, 0);
        step(11, 1, 0, 0, 4'b0000, 4'b0010, 4'b0000, 4'd13, F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // back-to-back LDM, SHR, DEC, JC, IN, invalid ADD, OUT, JZ
        step(13, 1, 0, 0, 4'b0001, 4'b0000, 4'b0001, 4'd0,  F_IMM,  0);
        step(31, 1, 0, 0, 4'b0010, 4'b0000, 4'b0011, 4'd0,  F_IMM,  0);
        step(5,  1, 0, 0, 4'b0100, 4'b0000, 4'b0111, 4'd10, F_ONE,  0);
        step(18, 1, 0, 0, 4'b1000, 4'b0000, 4'b1110, 4'd3,  F_JT3,  0);
        step(6,  1, 0, 0, 4'b0000, 4'b0000, 4'b1100, 4'd0,  F_IN,   0);
        step(25, 0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 4'd0,  F_NONE, 0);
        step(7,  1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_OUT,  0);
        step(16, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_JT1,  0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // CALL: two push words, ADD ignored while busy, then accepted
        step(20, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS, 1);
        step(25, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS | F_WS1, 1);
        step(25, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        step(25, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0010, 4'd5,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // RETI: flags step then two PC pops
        step(22, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_FR, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_PCR, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_PCR | F_WS1, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // ADD, LDD, stall for two cycles, release
        step(25, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, 4'd0,  F_NONE, 0);
        step(10, 1, 0, 0, 4'b0001, 4'b0000, 4'b0011, 4'd5,  F_NONE, 0);
        step(0,  0, 1, 0, 4'b0001, 4'b0000, 4'b0101, 4'd0,  F_NONE, 0);
        step(0,  0, 1, 0, 4'b0001, 4'b0000, 4'b1001, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 4'd13, F_NONE, 0);
        step(0,  0, 0, 0, 4'b0100, 4'b0000, 4'b0100, 4'd0,  F_NONE, 0);
        // stall and flush together clear stages 0-1, older stages advance
        step(25, 1, 0, 0, 4'b1000, 4'b0000, 4'b1001, 4'd0,  F_NONE, 0);
        step(10, 1, 0, 0, 4'b0001, 4'b0000, 4'b0011, 4'd5,  F_NONE, 0);
        step(25, 1, 1, 1, 4'b0000, 4'b0000, 4'b0100, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 4'd0,  F_NONE, 0);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // flush aborts CALL; following RET starts at word 0
        step(20, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS, 1);
        step(0,  0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        step(21, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_PCR, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_PCR | F_WS1, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // stall holds the CALL word counter
        step(20, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS, 1);
        step(0,  0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS | F_WS1, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);
        // CALL interrupted by reset at word 1
        step(20, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_PUSH | F_PCS | F_WS1, 1);

        @(negedge clk);
        bus.opcode      = '0;
        bus.instr_valid = 1'b0;
        rst             = 1'b1;
        #1;
        compare("reset_mid_call", snap(), 29'd0);
        @(negedge clk);
        rst = 1'b0;

        step(21, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_PCR, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_POP | F_PCR | F_WS1, 1);
        step(0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0,  F_NONE, 0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending snapshots required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
